piso_serializer: RTL and testbench
==================================

Name: piso_serializer

Overview:
- Parallel-in/serial-out loader feeding the siso shift-register chain.
- Accepts a WIDTH-bit word over a valid/ready handshake and drives it one bit per clock onto a serial line, e.g. siso.i_d.
- Provides framing (o_last, o_busy), an optional inter-word gap, and a shift-enable stall.
- Replaces hand-driven bit patterns at the siso input.

Parameters:
- WIDTH, 4: word length in bits; legal range 2..32.
- LSB_FIRST, 1: 1 = bit 0 shifted out first; 0 = bit WIDTH-1 first.
- GAP_CYCLES, 0: idle cycles inserted after each word before o_ready reasserts; range 0..15.
- IDLE_LVL, 0: level driven on o_d when no word is being shifted.

Ports:
- i_clk  input  1  rising-edge clock.
- i_rst  input  1  asynchronous active-low reset.
- i_valid  input  1  upstream word valid.
- i_word  input  WIDTH  parallel word; sampled only on an accept edge.
- o_ready  output  1  block can accept a word.
- i_en  input  1  shift enable; 0 stalls shifting (holds the current bit).
- o_d  output  1  serial data out (to siso.i_d).
- o_busy  output  1  high while in SHIFT or GAP.
- o_last  output  1  high while the final bit of a word is on o_d.

Behaviour:
- Reset (i_rst=0, asynchronous): state=IDLE, shift reg=0, bit counter=0, gap counter=0, o_ready=1, o_d=IDLE_LVL, o_busy=0, o_last=0. Reset mid-word aborts the word; remaining bits are lost.
- FSM states: IDLE, SHIFT, GAP. All outputs are registered or decoded from registered state only; no combinational path from inputs to outputs.
- IDLE:
  - o_ready=1.
  - Accept on a rising edge with i_valid=1: latch i_word, counter=0, go to SHIFT.
  - i_en is ignored for the accept.
- SHIFT:
  - o_ready=0, o_busy=1.
  - o_d = current bit: i_word[cnt] if LSB_FIRST, else i_word[WIDTH-1-cnt].
  - At an edge with i_en=1: advance the counter.
  - At an edge with i_en=1 and cnt==WIDTH-1: go to GAP if GAP_CYCLES>0, else to IDLE.
  - At an edge with i_en=0: state, counter and o_d hold.
- Latency: the first bit appears on o_d in the cycle after the accept edge. Each bit is held for exactly one cycle per i_en=1 edge.
- o_last=1 exactly while in SHIFT with cnt==WIDTH-1; it stays high through stalls.
- GAP:
  - o_d=IDLE_LVL, o_busy=1, o_ready=0.
  - Counts GAP_CYCLES edges regardless of i_en, then goes to IDLE.
- Word period: minimum accept-to-accept spacing with i_en=1 is WIDTH+GAP_CYCLES+1 cycles.
- i_valid while o_ready=0 is not accepted; i_word changes during SHIFT have no effect, since the word is latched.
- Counter width: $clog2(WIDTH); the counter never exceeds WIDTH-1 (no wrap).
- Simultaneous reset and valid: reset wins; no accept.

Test Plan:
- Reset, then accept 4'b1101 with LSB_FIRST=1, i_en=1: o_d = 1,0,1,1 on the 4 cycles after accept; o_last high on the 4th cycle only; o_ready high again in the 5th cycle.
- LSB_FIRST=0, word 4'b1101: o_d = 1,1,0,1. Chain into siso: o_siso reproduces the same sequence delayed by the siso depth.
- Hold i_valid=1 continuously with words 4'hA then 4'h5, GAP_CYCLES=2: accepts are exactly 7 cycles apart; o_d=0 for 2 gap cycles; o_busy high for 6 cycles per word.
- Word 4'b0110, drop i_en for 3 cycles after the 2nd bit: the 2nd bit (1) is held 4 cycles total; o_last timing shifts by 3; no bit is lost.
- Assert i_rst=0 asynchronously mid-word (between edges, after bit 1): o_d=IDLE_LVL, o_busy=0, o_ready=1 immediately. After release, a new word 4'b0011 serializes cleanly as 1,1,0,0.
- Toggle i_word and pulse i_valid while busy: no second accept, and the output sequence matches the originally latched word.

Source files
------------

// File: rtl/piso_serializer.sv
// Parallel-in/serial-out loader: accepts a WIDTH-bit word over valid/ready and
// drives it one bit per enabled clock onto o_d, with framing and an optional gap.
module piso_serializer #(
  parameter int unsigned WIDTH      = 4,
  parameter bit          LSB_FIRST  = 1'b1,
  parameter int unsigned GAP_CYCLES = 0,
  parameter bit          IDLE_LVL   = 1'b0
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_valid,
  input  logic [WIDTH-1:0] i_word,
  output logic             o_ready,
  input  logic             i_en,
  output logic             o_d,
  output logic             o_busy,
  output logic             o_last
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int GW = 4;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
  localparam logic [GW-1:0] GAP_LAST = GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    GAP   = 2'd2
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [WIDTH-1:0]  sreg;
  logic [CW-1:0]     cnt;
  logic [GW-1:0]     gap_cnt;
  logic              cnt_done;
  logic              gap_done;
  logic              head_bit;

  assign cnt_done = (cnt == CNT_LAST);
  assign gap_done = (gap_cnt == GAP_LAST);
  // The bit on the line is always the head of the shift register.
  assign head_bit = LSB_FIRST ? sreg[0] : sreg[WIDTH-1];

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values; blocking here would create order-dependent simulation.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // NOTE: every signal written here gets a default first, so no path through
  // the case statement leaves one unassigned and infers a latch.
  always_comb begin
    state_nxt = state;
    o_ready   = 1'b0;
    o_busy    = 1'b0;
    o_last    = 1'b0;
    o_d       = IDLE_LVL;
    unique case (state)
      IDLE: begin
        o_ready = 1'b1;
        if (i_valid) begin
          state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        o_busy = 1'b1;
        o_d    = head_bit;
        o_last = cnt_done;
        if (i_en && cnt_done) begin
          state_nxt = (GAP_CYCLES > 0) ? GAP : IDLE;
        end
      end
      GAP: begin
        o_busy = 1'b1;
        if (gap_done) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // NOTE: the shift register is a handful of flops, not a memory array, so it is
  // cleared on reset; an aborted word leaves nothing behind to leak out later.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      sreg    <= '0;
      cnt     <= '0;
      gap_cnt <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (i_valid) begin
            sreg    <= i_word;
            cnt     <= '0;
            gap_cnt <= '0;
          end
        end
        SHIFT: begin
          if (i_en) begin
            if (LSB_FIRST) begin
              sreg <= {1'b0, sreg[WIDTH-1:1]};
            end else begin
              sreg <= {sreg[WIDTH-2:0], 1'b0};
            end
            // Return to zero on the final bit instead of wrapping past WIDTH-1.
            cnt <= cnt_done ? '0 : cnt + CW'(1);
          end
        end
        GAP: begin
          gap_cnt <= gap_done ? '0 : gap_cnt + GW'(1);
        end
        default: begin
          cnt     <= '0;
          gap_cnt <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_piso_serializer.sv
// Bench for piso_serializer: three instances (LSB-first, MSB-first with idle
// level 1, LSB-first with a 2-cycle gap) checked cycle by cycle from a queue.
module tb_piso_serializer;

  localparam int W = 4;
  localparam logic [2:0] IDLE_LVL = 3'b010;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [2:0]   valid;
  logic [W-1:0] word;
  logic         en;
  logic [2:0]   ready, od, busy, last;

  always #5 clk = ~clk;

  piso_serializer #(.WIDTH(W), .LSB_FIRST(1'b1), .GAP_CYCLES(0), .IDLE_LVL(1'b0)) u0 (
    .i_clk(clk), .i_rst(rst_n), .i_valid(valid[0]), .i_word(word), .o_ready(ready[0]),
    .i_en(en), .o_d(od[0]), .o_busy(busy[0]), .o_last(last[0]));

  piso_serializer #(.WIDTH(W), .LSB_FIRST(1'b0), .GAP_CYCLES(0), .IDLE_LVL(1'b1)) u1 (
    .i_clk(clk), .i_rst(rst_n), .i_valid(valid[1]), .i_word(word), .o_ready(ready[1]),
    .i_en(en), .o_d(od[1]), .o_busy(busy[1]), .o_last(last[1]));

  piso_serializer #(.WIDTH(W), .LSB_FIRST(1'b1), .GAP_CYCLES(2), .IDLE_LVL(1'b0)) u2 (
    .i_clk(clk), .i_rst(rst_n), .i_valid(valid[2]), .i_word(word), .o_ready(ready[2]),
    .i_en(en), .o_d(od[2]), .o_busy(busy[2]), .o_last(last[2]));

  typedef struct packed {
    logic d;
    logic last;
    logic busy;
    logic ready;
  } obs_t;

  // exp lists the serial bits in output order: exp[0] is the first bit on o_d.
  typedef struct {
    int          dut;
    logic [3:0]  word;
    logic [3:0]  exp;
    logic [15:0] en_mask;
    logic        acc_en;
    logic        noise;
    logic        hold;
    logic [3:0]  next;
  } vec_t;

  obs_t q0[$];
  obs_t q1[$];
  obs_t q2[$];
  vec_t vecs[9];
  int   vectors = 0;
  int   miscompares = 0;
  int   cyc = 0;
  int   acc[$];

  task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %b want %b (d,last,busy,ready) at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d want %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int gap_of(input int k);
    return (k == 2) ? 2 : 0;
  endfunction

  function automatic obs_t idle_obs(input int k);
    return {IDLE_LVL[k], 1'b0, 1'b0, 1'b1};
  endfunction

  task automatic push(input int k, input obs_t r);
    case (k)
      0: q0.push_back(r);
      1: q1.push_back(r);
      default: q2.push_back(r);
    endcase
  endtask

  // Scoreboard consumer: one expected record per DUT per cycle; idle when empty.
  always @(negedge clk) begin
    obs_t e;
    e = (q0.size() > 0) ? q0.pop_front() : idle_obs(0);
    check("dut0 lsb", {od[0], last[0], busy[0], ready[0]}, e);
    e = (q1.size() > 0) ? q1.pop_front() : idle_obs(1);
    check("dut1 msb", {od[1], last[1], busy[1], ready[1]}, e);
    e = (q2.size() > 0) ? q2.pop_front() : idle_obs(2);
    check("dut2 gap", {od[2], last[2], busy[2], ready[2]}, e);
  end

  always @(posedge clk) begin
    cyc++;
    if (valid[2] && ready[2]) acc.push_back(cyc);
  end

  // Entered at posedge+1 with the target idle; returns at posedge+1 once it is idle again.
  task automatic send(input vec_t v);
    int   idx;
    int   n;
    obs_t r;
    valid[v.dut] = 1'b1;
    word = v.word;
    en = v.acc_en;
    @(posedge clk); #1;
    idx = 0;
    n = 0;
    for (int c = 0; idx < W && c < 16; c++) begin
      r = {v.exp[idx], (idx == W - 1), 1'b1, 1'b0};
      push(v.dut, r);
      if (v.en_mask[c]) idx++;
      n++;
    end
    for (int g = 0; g < gap_of(v.dut); g++) begin
      push(v.dut, {IDLE_LVL[v.dut], 1'b0, 1'b1, 1'b0});
      n++;
    end
    for (int c = 0; c < n; c++) begin
      en = (c < 16) ? v.en_mask[c] : 1'b1;
      if (v.hold) begin
        valid[v.dut] = 1'b1;
        word = v.next;
      end else if (v.noise) begin
        valid[v.dut] = 1'($urandom_range(0, 1));
        word = 4'($urandom);
      end else begin
        valid[v.dut] = 1'b0;
      end
      @(posedge clk); #1;
    end
    if (!v.hold) valid[v.dut] = 1'b0;
    en = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    valid = '0;
    word  = '0;
    en    = 1'b1;

    //          dut word     exp      en_mask   acc  noise hold next
    vecs[0] = '{0, 4'b1101, 4'b1101, 16'hFFFF, 1'b1, 1'b0, 1'b0, 4'h0};
    vecs[1] = '{1, 4'b1101, 4'b1011, 16'hFFFF, 1'b1, 1'b0, 1'b0, 4'h0};
    vecs[2] = '{0, 4'b0110, 4'b0110, 16'hFFF1, 1'b1, 1'b0, 1'b0, 4'h0};
    vecs[3] = '{0, 4'b1000, 4'b1000, 16'hFFE7, 1'b1, 1'b0, 1'b0, 4'h0};
    vecs[4] = '{1, 4'b0100, 4'b0010, 16'hFFFF, 1'b0, 1'b0, 1'b0, 4'h0};
    vecs[5] = '{2, 4'hA,    4'b1010, 16'h000F, 1'b1, 1'b0, 1'b1, 4'h5};
    vecs[6] = '{2, 4'h5,    4'b0101, 16'hFFFF, 1'b1, 1'b0, 1'b0, 4'h0};
    vecs[7] = '{2, 4'b1110, 4'b1110, 16'hFFFB, 1'b1, 1'b1, 1'b0, 4'h0};
    vecs[8] = '{0, 4'b0011, 4'b0011, 16'hFFFF, 1'b1, 1'b0, 1'b0, 4'h0};

    #3;
    check("reset dut0", {od[0], last[0], busy[0], ready[0]}, 4'b0001);
    check("reset dut1", {od[1], last[1], busy[1], ready[1]}, 4'b1001);
    check("reset dut2", {od[2], last[2], busy[2], ready[2]}, 4'b0001);
    #9 rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 8; i++) begin
      if (i == 5) acc.delete();
      send(vecs[i]);
      if (i == 6) begin
        check_int("dut2 accept count", acc.size(), 2);
        if (acc.size() >= 2) check_int("dut2 accept spacing", acc[1] - acc[0], 7);
      end
    end

    // Asynchronous reset in the middle of word 1011, after two bits went out.
    valid[0] = 1'b1;
    word = 4'b1011;
    en = 1'b1;
    @(posedge clk); #1;
    push(0, {1'b1, 1'b0, 1'b1, 1'b0});
    push(0, {1'b1, 1'b0, 1'b1, 1'b0});
    valid[0] = 1'b0;
    @(posedge clk);
    @(posedge clk); #2;
    rst_n = 1'b0;
    q0.delete();
    #1;
    check("async reset dut0", {od[0], last[0], busy[0], ready[0]}, 4'b0001);
    // Valid held across an edge while reset is low must not be accepted.
    valid[0] = 1'b1;
    @(posedge clk); #1;
    valid[0] = 1'b0;
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    send(vecs[8]);

    repeat (3) @(posedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
